// File: rtl/apb_axi_ab_if_pkg.sv
// Shared constants and types for the APB register file / AXI A-B queue block.
package apb_axi_ab_if_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;

    localparam logic [11:0] REG_CTRL    = 12'h000;
    localparam logic [11:0] REG_TIMING0 = 12'h004;
    localparam logic [11:0] REG_TIMING1 = 12'h008;
    localparam logic [11:0] REG_STATUS  = 12'h00C;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } a_req_t;

endpackage

// File: rtl/apb_axi_ab_if_fifo.sv
// Generic synchronous FIFO; extra pointer MSB distinguishes full from empty.
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (PW+1)'(1);
        if (do_pop)  rd_d = rd_q + (PW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: nothing is visible until a pointer moves.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/apb_axi_ab_if.sv
// APB config registers plus AXI address-request and write-response queues.
module apb_axi_ab_if
    import apb_axi_ab_if_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = AXI_ID_W,
    parameter int AXI_ADDR_WIDTH = AXI_ADDR_W,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [11:0]               paddr,
    input  logic [31:0]               pwdata,
    output logic                      pready,
    output logic [31:0]               prdata,
    output logic                      pslverr,
    input  logic                      avalid,
    output logic                      aready,
    input  logic [AXI_ID_WIDTH-1:0]   aid,
    input  logic [AXI_ADDR_WIDTH-1:0] aaddr,
    input  logic [7:0]                alen,
    input  logic [2:0]                asize,
    input  logic [1:0]                aburst,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [AXI_ID_WIDTH-1:0]   req_id,
    output logic [AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]                req_len,
    output logic [2:0]                req_size,
    output logic [1:0]                req_burst,
    input  logic                      wdone_valid,
    output logic                      wdone_ready,
    input  logic [AXI_ID_WIDTH-1:0]   wdone_id,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [AXI_ID_WIDTH-1:0]   bid,
    output logic [1:0]                bresp,
    output logic [31:0]               cfg_ctrl,
    output logic [31:0]               cfg_timing0,
    output logic [31:0]               cfg_timing1,
    input  logic [31:0]               status
);
    localparam int AW = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13;

    logic [31:0] ctrl_q, ctrl_d, tim0_q, tim0_d, tim1_q, tim1_d;
    logic        access, mapped, err;
    logic [31:0] rd_val;

    assign access = psel && penable && rst_n;

    always_comb begin
        mapped = 1'b1;
        rd_val = '0;
        case (paddr)
            REG_CTRL:    rd_val = ctrl_q;
            REG_TIMING0: rd_val = tim0_q;
            REG_TIMING1: rd_val = tim1_q;
            REG_STATUS:  rd_val = status;
            default:     mapped = 1'b0;
        endcase
    end

    // Misaligned addresses never match a mapped offset, but are flagged explicitly too.
    assign err     = !mapped || (paddr[1:0] != 2'b00) || (pwrite && paddr == REG_STATUS);
    assign pready  = access;
    assign pslverr = access && err;
    assign prdata  = (access && !err) ? rd_val : '0;

    always_comb begin
        ctrl_d = ctrl_q;
        tim0_d = tim0_q;
        tim1_d = tim1_q;
        if (access && pwrite && !err) begin
            case (paddr)
                REG_CTRL:    ctrl_d = pwdata;
                REG_TIMING0: tim0_d = pwdata;
                REG_TIMING1: tim1_d = pwdata;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            tim0_q <= '0;
            tim1_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            tim0_q <= tim0_d;
            tim1_q <= tim1_d;
        end
    end

    assign cfg_ctrl    = ctrl_q;
    assign cfg_timing0 = tim0_q;
    assign cfg_timing1 = tim1_q;

    logic          a_full, a_empty, b_full, b_empty;
    logic [AW-1:0] a_head;

    assign aready    = rst_n && !a_full;
    assign req_valid = !a_empty;
    assign {req_id, req_addr, req_len, req_size, req_burst} = a_head;

    sal_sync_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_a_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (avalid && aready),
        .data_i  ({aid, aaddr, alen, asize, aburst}),
        .pop_i   (req_valid && req_ready),
        .full_o  (a_full),
        .empty_o (a_empty),
        .data_o  (a_head)
    );

    assign wdone_ready = rst_n && !b_full;
    assign bvalid      = !b_empty;
    assign bresp       = BRESP_OKAY;

    sal_sync_fifo #(.WIDTH(AXI_ID_WIDTH), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wdone_valid && wdone_ready),
        .data_i  (wdone_id),
        .pop_i   (bvalid && bready),
        .full_o  (b_full),
        .empty_o (b_empty),
        .data_o  (bid)
    );

endmodule

// File: tb/tb_apb_axi_ab_if.sv
// Scoreboard bench: APB register access, A/B queue ordering, back-pressure and reset.
module tb_apb_axi_ab_if;
    import apb_axi_ab_if_pkg::*;

    logic        clk = 0, rst_n = 0;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [11:0] paddr = 0;
    logic [31:0] pwdata = 0, prdata;
    logic        pready, pslverr;
    logic        avalid = 0, aready;
    logic [3:0]  aid = 0;
    logic [31:0] aaddr = 0;
    logic [7:0]  alen = 0;
    logic [2:0]  asize = 0;
    logic [1:0]  aburst = 0;
    logic        req_valid, req_ready = 0;
    logic [3:0]  req_id;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        wdone_valid = 0, wdone_ready;
    logic [3:0]  wdone_id = 0;
    logic        bvalid, bready = 0;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [31:0] cfg_ctrl, cfg_timing0, cfg_timing1;
    logic [31:0] status = 32'hA5A5_0001;

    int n_cmp = 0, n_bad = 0;
    a_req_t      a_exp[$];
    logic [3:0]  b_exp[$];

    apb_axi_ab_if dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .avalid(avalid), .aready(aready), .aid(aid), .aaddr(aaddr), .alen(alen),
        .asize(asize), .aburst(aburst), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_burst(req_burst), .wdone_valid(wdone_valid), .wdone_ready(wdone_ready),
        .wdone_id(wdone_id), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .cfg_ctrl(cfg_ctrl), .cfg_timing0(cfg_timing0), .cfg_timing1(cfg_timing1),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output logic rdy);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1;
        #1;
        rd = prdata; err = pslverr; rdy = pready;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    // Drives one A beat for a single cycle; scoreboards it only if accepted.
    task automatic a_push(input a_req_t r, output logic ok);
        @(negedge clk);
        avalid = 1; {aid, aaddr, alen, asize, aburst} = r;
        #1;
        ok = aready;
        if (ok) a_exp.push_back(r);
        @(negedge clk);
        avalid = 0;
    endtask

    task automatic b_push(input logic [3:0] id, output logic ok);
        @(negedge clk);
        wdone_valid = 1; wdone_id = id;
        #1;
        ok = wdone_ready;
        if (ok) b_exp.push_back(id);
        @(negedge clk);
        wdone_valid = 0;
    endtask

    task automatic test_reset;
        psel = 1; penable = 1;
        #3;
        n_cmp++;
        if ({pready, pslverr, prdata, aready, wdone_ready, req_valid, bvalid, bresp} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h ar=%b wr=%b rv=%b bv=%b br=%b, need all 0",
                     pready, pslverr, prdata, aready, wdone_ready, req_valid, bvalid, bresp);
        end
        n_cmp++;
        if ({cfg_ctrl, cfg_timing0, cfg_timing1} !== '0) begin
            n_bad++; $display("FAIL reset_cfg: got %h %h %h, need 0", cfg_ctrl, cfg_timing0, cfg_timing1);
        end
        psel = 0; penable = 0;
        @(negedge clk); rst_n = 1;
        #1;
        n_cmp++;
        if (aready !== 1'b1 || wdone_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release: aready=%b wdone_ready=%b, need 1 1", aready, wdone_ready);
        end
    endtask

    task automatic test_apb_rw;
        logic [31:0] rd; logic err, rdy;
        #1;
        n_cmp++;
        if (pready !== 1'b0) begin n_bad++; $display("FAIL idle_pready: got %b need 0", pready); end
        apb(1, 12'h004, 32'h0000_1234, rd, err, rdy);
        n_cmp++;
        if (rdy !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL wr_t0_resp: pready=%b pslverr=%b, need 1 0", rdy, err);
        end
        n_cmp++;
        if (cfg_timing0 !== 32'h1234) begin
            n_bad++; $display("FAIL cfg_timing0: got %h need 00001234", cfg_timing0);
        end
        apb(0, 12'h004, 32'h0, rd, err, rdy);
        n_cmp++;
        if (rd !== 32'h1234 || err !== 1'b0) begin
            n_bad++; $display("FAIL rd_t0: prdata=%h pslverr=%b, need 00001234 0", rd, err);
        end
        apb(1, 12'h000, 32'hDEAD_BEEF, rd, err, rdy);
        apb(1, 12'h008, 32'h0BAD_F00D, rd, err, rdy);
        n_cmp++;
        if (cfg_ctrl !== 32'hDEAD_BEEF || cfg_timing1 !== 32'h0BAD_F00D) begin
            n_bad++; $display("FAIL cfg_ctrl_t1: got %h %h need deadbeef 0badf00d", cfg_ctrl, cfg_timing1);
        end
        apb(0, 12'h008, 32'h0, rd, err, rdy);
        n_cmp++;
        if (rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rd_t1: got %h need 0badf00d", rd); end
        apb(0, 12'h00C, 32'h0, rd, err, rdy);
        n_cmp++;
        if (rd !== 32'hA5A5_0001 || err !== 1'b0) begin
            n_bad++; $display("FAIL rd_status: got %h err=%b need a5a50001 0", rd, err);
        end
    endtask

    task automatic test_apb_err;
        logic [31:0] rd; logic err, rdy;
        apb(0, 12'h010, 32'h0, rd, err, rdy);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0 || rdy !== 1'b1) begin
            n_bad++; $display("FAIL rd_unmapped: pslverr=%b prdata=%h pready=%b, need 1 0 1", err, rd, rdy);
        end
        apb(1, 12'h00C, 32'hFFFF_FFFF, rd, err, rdy);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL wr_status: pslverr=%b prdata=%h, need 1 0", err, rd);
        end
        apb(0, 12'h00C, 32'h0, rd, err, rdy);
        n_cmp++;
        if (rd !== 32'hA5A5_0001) begin n_bad++; $display("FAIL status_after_wr: got %h need a5a50001", rd); end
        apb(1, 12'h006, 32'h5555_5555, rd, err, rdy);
        n_cmp++;
        if (err !== 1'b1 || cfg_timing0 !== 32'h1234) begin
            n_bad++; $display("FAIL wr_misaligned: pslverr=%b timing0=%h, need 1 00001234", err, cfg_timing0);
        end
    endtask

    task automatic test_a_queue;
        logic ok; a_req_t r; logic [31:0] held;
        int guard;
        req_ready = 0;
        r = '{id: 4'd0, addr: 32'h0, len: 8'd0, size: 3'd2, burst: 2'd1};
        @(negedge clk);
        avalid = 1; {aid, aaddr, alen, asize, aburst} = r;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0) begin n_bad++; $display("FAIL a_no_bypass: req_valid=%b need 0", req_valid); end
        if (aready) a_exp.push_back(r);
        @(negedge clk); avalid = 0;
        n_cmp++;
        if (req_valid !== 1'b1) begin n_bad++; $display("FAIL a_latency: req_valid=%b need 1", req_valid); end
        r = '{id: 4'd0, addr: 32'h4, len: 8'd0, size: 3'd2, burst: 2'd1};
        a_push(r, ok);
        n_cmp++;
        if (ok !== 1'b1 || aready !== 1'b0) begin
            n_bad++; $display("FAIL a_full: accepted=%b aready=%b, need 1 0", ok, aready);
        end
        held = req_addr;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_addr !== held || req_valid !== 1'b1) begin
            n_bad++; $display("FAIL a_stable: addr=%h valid=%b, need %h 1", req_addr, req_valid, held);
        end
        req_ready = 1;
        guard = 0;
        while (a_exp.size() > 0 && guard < 20) begin
            #1;
            if (req_valid) begin
                r = a_exp.pop_front();
                n_cmp++;
                if ({req_id, req_addr, req_len, req_size, req_burst} !== r) begin
                    n_bad++; $display("FAIL a_order: got id=%h addr=%h len=%h, need id=%h addr=%h len=%h",
                                      req_id, req_addr, req_len, r.id, r.addr, r.len);
                end
            end
            @(negedge clk); guard++;
        end
        #1;
        n_cmp++;
        if (guard >= 20 || req_valid !== 1'b0) begin
            n_bad++; $display("FAIL a_drain: guard=%0d req_valid=%b left=%0d, need drained", guard, req_valid, a_exp.size());
        end
        a_exp.delete();
    endtask

    task automatic test_back_to_back;
        a_req_t items[8]; a_req_t r;
        int sent = 0, guard = 0;
        for (int i = 0; i < 8; i++)
            items[i] = '{id: 4'($urandom), addr: $urandom, len: 8'($urandom), size: 3'($urandom), burst: 2'($urandom)};
        req_ready = 1;
        @(negedge clk);
        while ((sent < 8 || a_exp.size() > 0) && guard < 100) begin
            req_ready = ($urandom_range(0, 3) != 0);
            avalid = (sent < 8);
            if (sent < 8) {aid, aaddr, alen, asize, aburst} = items[sent];
            #1;
            if (req_valid && req_ready) begin
                r = a_exp.pop_front();
                n_cmp++;
                if ({req_id, req_addr, req_len, req_size, req_burst} !== r) begin
                    n_bad++; $display("FAIL b2b_order: got addr=%h id=%h, need addr=%h id=%h", req_addr, req_id, r.addr, r.id);
                end
            end
            if (avalid && aready) begin a_exp.push_back(items[sent]); sent++; end
            @(negedge clk); guard++;
        end
        avalid = 0; req_ready = 0;
        n_cmp++;
        if (guard >= 100) begin n_bad++; $display("FAIL b2b_timeout: sent=%0d left=%0d, need 8 0", sent, a_exp.size()); end
        a_exp.delete();
    endtask

    task automatic test_b_queue;
        logic ok; logic [3:0] e; int guard;
        bready = 0;
        b_push(4'd3, ok);
        b_push(4'd5, ok);
        n_cmp++;
        if (wdone_ready !== 1'b0 || bvalid !== 1'b1 || bid !== 4'd3) begin
            n_bad++; $display("FAIL b_full: wdone_ready=%b bvalid=%b bid=%h, need 0 1 3", wdone_ready, bvalid, bid);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bid !== 4'd3 || bvalid !== 1'b1) begin
            n_bad++; $display("FAIL b_stable: bid=%h bvalid=%b, need 3 1", bid, bvalid);
        end
        bready = 1;
        guard = 0;
        while (b_exp.size() > 0 && guard < 20) begin
            #1;
            if (bvalid) begin
                e = b_exp.pop_front();
                n_cmp++;
                if (bid !== e || bresp !== 2'b00) begin
                    n_bad++; $display("FAIL b_order: bid=%h bresp=%b, need %h 00", bid, bresp, e);
                end
            end
            @(negedge clk); guard++;
        end
        #1;
        n_cmp++;
        if (guard >= 20 || bvalid !== 1'b0) begin
            n_bad++; $display("FAIL b_drain: guard=%0d bvalid=%b, need drained", guard, bvalid);
        end
        bready = 0;
        b_exp.delete();
    endtask

    task automatic test_reset_mid;
        logic ok; a_req_t r;
        req_ready = 0; bready = 0;
        for (int i = 0; i < 2; i++) begin
            r = '{id: 4'(i), addr: 32'(i * 16), len: 8'd1, size: 3'd2, burst: 2'd1};
            a_push(r, ok);
            b_push(4'(i + 7), ok);
        end
        #1;
        n_cmp++;
        if (aready !== 1'b0 || wdone_ready !== 1'b0 || req_valid !== 1'b1 || bvalid !== 1'b1) begin
            n_bad++; $display("FAIL mid_fill: aready=%b wdone_ready=%b rv=%b bv=%b, need 0 0 1 1",
                              aready, wdone_ready, req_valid, bvalid);
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0 || bvalid !== 1'b0 || {cfg_ctrl, cfg_timing0, cfg_timing1} !== '0) begin
            n_bad++; $display("FAIL mid_reset: rv=%b bv=%b ctrl=%h t0=%h t1=%h, need all 0",
                              req_valid, bvalid, cfg_ctrl, cfg_timing0, cfg_timing1);
        end
        a_exp.delete(); b_exp.delete();
        @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (req_valid !== 1'b0 || bvalid !== 1'b0 || aready !== 1'b1 || wdone_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_release: rv=%b bv=%b ar=%b wr=%b, need 0 0 1 1",
                              req_valid, bvalid, aready, wdone_ready);
        end
    endtask

    initial begin
        test_reset();
        test_apb_rw();
        test_apb_err();
        test_a_queue();
        test_back_to_back();
        test_b_queue();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_axi_ab_if.md
APB_AXI_AB_IF -- requirements
Module: apb_axi_ab_if

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 4, AXI transaction ID width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI byte-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2 (power of two, >=2), entries per A and B queue.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 psel, penable, pwrite  in  1 each  APB slave control.
REQ-007 paddr  in  12  APB byte address; pwdata  in  32  write data.
REQ-008 pready  out  1; prdata  out  32; pslverr  out  1  APB response.
REQ-009 avalid  in  1; aready  out  1  AXI address-channel handshake.
REQ-010 aid  in  AXI_ID_WIDTH; aaddr  in  AXI_ADDR_WIDTH; alen  in  8; asize  in  3; aburst  in  2  address payload.
REQ-011 req_valid  out  1; req_ready  in  1; req_id, req_addr, req_len, req_size, req_burst  out  (widths as REQ-010)  queued request to scheduler.
REQ-012 wdone_valid  in  1; wdone_ready  out  1; wdone_id  in  AXI_ID_WIDTH  write-completion from scheduler.
REQ-013 bvalid  out  1; bready  in  1; bid  out  AXI_ID_WIDTH; bresp  out  2  AXI write response.
REQ-014 cfg_ctrl, cfg_timing0, cfg_timing1  out  32 each  register contents; status  in  32  read-only status.

Function
REQ-015 APB: zero wait states; pready SHALL be 1 whenever psel && penable, else 0.
REQ-016 APB map: 0x000 CTRL (RW), 0x004 TIMING0 (RW), 0x008 TIMING1 (RW), 0x00C STATUS (RO, returns status input).
REQ-017 Write SHALL update the register on the access-phase edge (psel && penable && pwrite); cfg_* reflects new value next cycle.
REQ-018 prdata SHALL be combinational from paddr during access phase; 0 otherwise or when unmapped.
REQ-019 pslverr SHALL be 1 in access phase for unmapped address, non-word-aligned paddr[1:0]!=0, or write to STATUS; such writes are discarded.
REQ-020 A queue: FIFO_DEPTH-entry FIFO storing {aid,aaddr,alen,asize,aburst}; aready = !full (no combinational dependence on req_ready).
REQ-021 Push on avalid && aready; pop on req_valid && req_ready; req_valid = !empty; req_* = head entry; order preserved.
REQ-022 Simultaneous push and pop when full SHALL NOT be accepted (aready already 0); when empty, push-then-output takes one cycle (no bypass).
REQ-023 B queue: FIFO_DEPTH-entry FIFO of wdone_id; wdone_ready = !full; bvalid = !empty; bid = head; pop on bvalid && bready.
REQ-024 bresp SHALL always be 2'b00 (OKAY).
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty via an extra pointer MSB; simultaneous push/pop on non-full non-empty keeps count unchanged.
REQ-026 Payload on req_*/bid SHALL stay stable while valid and not ready.

Reset
REQ-027 On rst_n=0 (asynchronous): CTRL=0, TIMING0=0, TIMING1=0, both FIFOs empty.
REQ-028 During reset outputs: pready=0, pslverr=0, prdata=0, aready=1 after release only (0 while in reset), req_valid=0, wdone_ready=0 while in reset, bvalid=0, bresp=0.
REQ-029 Reset mid-transaction SHALL discard all queued entries; nothing is replayed after release.

Structure
REQ-030 Shared package SHALL hold register offsets, AXI_ID/ADDR widths, BRESP_OKAY constant, and the A-request struct typedef.
REQ-031 One generic sub-module sal_sync_fifo (parameterised width/depth) SHALL be instantiated twice (A and B queues); APB register decode is inline.

Verification
REQ-032 APB write 0x004=0x0000_1234, read 0x004 -> prdata=0x0000_1234, pslverr=0, cfg_timing0=0x1234.
REQ-033 APB read 0x010 and write 0x00C -> pslverr=1 both; STATUS unchanged, prdata=0.
REQ-034 Two A transfers (id0,addr0x0,len0) then (id0,addr0x4,len0) with req_ready=0 -> both accepted, aready=0 after second (depth 2); releasing req_ready yields addr 0x0 then 0x4 in order.
REQ-035 wdone_id=3 then 5 with bready=0 -> bvalid=1, bid=3 held stable; bready=1 -> bid 3 then 5, bresp=0, then bvalid=0.
REQ-036 Assert rst_n=0 with both queues full -> req_valid=0, bvalid=0, cfg_*=0 immediately; queues empty after release.
